// File: rtl/timer_sequencer.sv
// Sequences a 4-entry interval table through an external countdown timer.
// Define TIMER_SEQ_LOOP_EN to honour the loop input; otherwise loop is ignored.
module timer_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       go,
   input  logic       abort,
   input  logic       loop,
   input  logic [1:0] seg_count,
   input  logic       cfg_we,
   input  logic [1:0] cfg_addr,
   input  logic [7:0] cfg_data,
   output logic       tmr_rst,
   output logic       tmr_start,
   output logic       tmr_mode,
   output logic [7:0] tmr_set,
   input  logic       tmr_done,
   output logic       busy,
   output logic [1:0] seg_idx,
   output logic       seg_pulse,
   output logic       seq_done
);

   typedef enum logic [2:0] {
      IDLE, CLEAR, ARM, WAIT, NEXT, ABORT
   } state_t;

   state_t     state;
   logic [7:0] tbl [4];
   logic       done_q;
   logic       loop_en;
   logic [7:0] cur;
   logic       done_rise;

`ifdef TIMER_SEQ_LOOP_EN
   assign loop_en = loop;
`else
   assign loop_en = loop & 1'b0;
`endif

   assign cur       = tbl[seg_idx];
   assign done_rise = tmr_done & ~done_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         seg_idx   <= 2'd0;
         done_q    <= 1'b0;
         tmr_rst   <= 1'b0;
         tmr_start <= 1'b0;
         tmr_mode  <= 1'b0;
         tmr_set   <= 8'd0;
         busy      <= 1'b0;
         seg_pulse <= 1'b0;
         seq_done  <= 1'b0;
         for (int i = 0; i < 4; i++) tbl[i] <= 8'd0;
      end else begin
         done_q    <= tmr_done;
         tmr_rst   <= 1'b0;
         tmr_start <= 1'b0;
         seg_pulse <= 1'b0;
         seq_done  <= 1'b0;
         if (cfg_we && !busy) tbl[cfg_addr] <= cfg_data;
         // abort outranks any same-cycle done edge
         if (state != IDLE && abort) begin
            state   <= ABORT;
            tmr_rst <= 1'b1;
            tmr_set <= 8'd0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (go && !abort) begin
                     state    <= CLEAR;
                     seg_idx  <= 2'd0;
                     tmr_rst  <= 1'b1;
                     busy     <= 1'b1;
                     tmr_mode <= 1'b1;
                  end
               end
               CLEAR: begin
                  if (cur != 8'd0) begin
                     state     <= ARM;
                     tmr_start <= 1'b1;
                     tmr_set   <= cur;
                  end else begin
                     state <= NEXT;
                  end
               end
               ARM: state <= WAIT;
               WAIT: begin
                  if (done_rise) begin
                     state     <= NEXT;
                     seg_pulse <= 1'b1;
                     tmr_set   <= 8'd0;
                  end
               end
               NEXT: begin
                  if (seg_idx < seg_count) begin
                     seg_idx <= seg_idx + 2'd1;
                     state   <= CLEAR;
                     tmr_rst <= 1'b1;
                  end else if (loop_en) begin
                     seg_idx <= 2'd0;
                     state   <= CLEAR;
                     tmr_rst <= 1'b1;
                  end else begin
                     state    <= IDLE;
                     seq_done <= 1'b1;
                     busy     <= 1'b0;
                     tmr_mode <= 1'b0;
                  end
               end
               ABORT: begin
                  state    <= IDLE;
                  seg_idx  <= 2'd0;
                  busy     <= 1'b0;
                  tmr_mode <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_timer_sequencer.sv
// Scoreboard bench for timer_sequencer with a behavioural countdown timer.
// Expected timer/status events are queued by stimulus and popped by a monitor.
module tb_timer_sequencer;

   logic       clk = 1'b0;
   logic       reset, go, abort, loop, cfg_we;
   logic [1:0] seg_count, cfg_addr;
   logic [7:0] cfg_data;
   logic       tmr_rst, tmr_start, tmr_mode;
   logic [7:0] tmr_set;
   logic       tmr_done = 1'b0;
   logic       busy, seg_pulse, seq_done;
   logic [1:0] seg_idx;

   always #5 clk = ~clk;

   timer_sequencer dut (
      .clk(clk), .reset(reset), .go(go), .abort(abort), .loop(loop),
      .seg_count(seg_count), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .tmr_rst(tmr_rst), .tmr_start(tmr_start),
      .tmr_mode(tmr_mode), .tmr_set(tmr_set), .tmr_done(tmr_done),
      .busy(busy), .seg_idx(seg_idx), .seg_pulse(seg_pulse),
      .seq_done(seq_done)
   );

   // countdown timer with active-high reset
   logic [7:0] cnt = 8'd0;
   logic       running = 1'b0;
   always @(posedge clk) begin
      if (tmr_rst) begin
         cnt <= 8'd0; running <= 1'b0; tmr_done <= 1'b0;
      end else if (tmr_start) begin
         cnt <= tmr_set; running <= 1'b1; tmr_done <= 1'b0;
      end else if (running) begin
         if (cnt <= 8'd1) begin
            running <= 1'b0; tmr_done <= 1'b1;
         end else begin
            cnt <= cnt - 8'd1;
         end
      end
   end

   localparam int K_START = 0;
   localparam int K_PULSE = 1;
   localparam int K_DONE  = 2;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  pulse_cnt = 0;
   bit  seen_idx1 = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int k, input int v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int k, input int v);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected event: kind %0d value %0d, expected none", k, v);
      end else begin
         e = exp_q.pop_front();
         check("event kind", k, e.kind);
         check("event value", v, e.val);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (seg_idx == 2'd1) seen_idx1 = 1'b1;
         if (tmr_start) begin
            check("tmr_mode at start", int'(tmr_mode), 1);
            observe(K_START, int'(tmr_set));
         end
         if (seg_pulse) begin
            pulse_cnt++;
            observe(K_PULSE, int'(seg_idx));
         end
         if (seq_done) observe(K_DONE, 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic pulse_go();
      go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!busy) break;
         tick();
      end
      check({name, " busy cleared"}, int'(busy), 0);
      tick();
      tick();
      check({name, " events drained"}, exp_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int p0;
      reset = 1'b0; go = 1'b0; abort = 1'b0; loop = 1'b0; cfg_we = 1'b0;
      seg_count = 2'd0; cfg_addr = 2'd0; cfg_data = 8'd0;
      tick();
      tick();
      check("reset busy", int'(busy), 0);
      check("reset outs", int'({tmr_rst, tmr_start, tmr_mode, seg_pulse, seq_done}), 0);
      check("reset tmr_set", int'(tmr_set), 0);
      check("reset seg_idx", int'(seg_idx), 0);
      reset = 1'b1;
      tick();

      // two-segment run and go latency
      wr(2'd0, 8'd5); wr(2'd1, 8'd3);
      seg_count = 2'd1;
      push(K_START, 5); push(K_PULSE, 0);
      push(K_START, 3); push(K_PULSE, 1); push(K_DONE, 0);
      pulse_go();
      check("latency tmr_rst", int'(tmr_rst), 1);
      check("busy after go", int'(busy), 1);
      tick();
      check("latency tmr_start", int'(tmr_start), 1);
      check("first tmr_set", int'(tmr_set), 5);
      wait_idle("two-seg", 200);

      // zero entry skipped
      wr(2'd0, 8'd4); wr(2'd1, 8'd0); wr(2'd2, 8'd6); wr(2'd3, 8'd0);
      seg_count = 2'd2;
      seen_idx1 = 1'b0;
      push(K_START, 4); push(K_PULSE, 0);
      push(K_START, 6); push(K_PULSE, 2); push(K_DONE, 0);
      pulse_go();
      wait_idle("skip", 200);
      check("seg_idx visited 1", int'(seen_idx1), 1);

      // config write ignored while busy
      wr(2'd0, 8'd5);
      seg_count = 2'd0;
      push(K_START, 5); push(K_PULSE, 0); push(K_DONE, 0);
      pulse_go();
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd9;
      tick(); tick();
      cfg_we = 1'b0;
      wait_idle("busy write", 200);
      push(K_START, 5); push(K_PULSE, 0); push(K_DONE, 0);
      pulse_go();
      wait_idle("rerun", 200);

      // go with abort in IDLE
      go = 1'b1; abort = 1'b1;
      tick();
      go = 1'b0; abort = 1'b0;
      check("go+abort busy", int'(busy), 0);
      tick();
      check("go+abort busy later", int'(busy), 0);

      // abort during WAIT
      wr(2'd0, 8'd20); wr(2'd1, 8'd3);
      seg_count = 2'd1;
      push(K_START, 20);
      p0 = pulse_cnt;
      pulse_go();
      tick(); tick(); tick(); tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort tmr_rst", int'(tmr_rst), 1);
      check("abort busy", int'(busy), 1);
      tick();
      check("after abort busy", int'(busy), 0);
      check("after abort tmr_rst", int'(tmr_rst), 0);
      tick(); tick();
      check("abort no pulse", pulse_cnt, p0);
      check("abort events drained", exp_q.size(), 0);
      push(K_START, 20); push(K_PULSE, 0);
      push(K_START, 3); push(K_PULSE, 1); push(K_DONE, 0);
      pulse_go();
      check("restart seg_idx", int'(seg_idx), 0);
      wait_idle("restart", 300);

      // loop behaviour
      wr(2'd0, 8'd2);
      seg_count = 2'd0;
      loop = 1'b1;
`ifdef TIMER_SEQ_LOOP_EN
      for (int k = 0; k < 3; k++) begin
         push(K_START, 2); push(K_PULSE, 0);
      end
      p0 = pulse_cnt;
      pulse_go();
      for (int i = 0; i < 200; i++) begin
         if (pulse_cnt >= p0 + 3) break;
         tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("loop pulses", pulse_cnt, p0 + 3);
      wait_idle("loop", 20);
`else
      push(K_START, 2); push(K_PULSE, 0); push(K_DONE, 0);
      pulse_go();
      wait_idle("no-loop", 200);
`endif
      loop = 1'b0;

      // async reset during WAIT
      wr(2'd0, 8'd5); wr(2'd1, 8'd3);
      seg_count = 2'd1;
      push(K_START, 5);
      pulse_go();
      tick(); tick(); tick();
      #2 reset = 1'b0;
      #1;
      check("async busy", int'(busy), 0);
      check("async outs", int'({tmr_rst, tmr_start, tmr_mode, seg_pulse, seq_done}), 0);
      check("async tmr_set", int'(tmr_set), 0);
      check("async seg_idx", int'(seg_idx), 0);
      #1 reset = 1'b1;
      tick();
      check("reset events drained", exp_q.size(), 0);

      // table cleared by reset: all-zero run
      seg_count = 2'd3;
      p0 = pulse_cnt;
      push(K_DONE, 0);
      pulse_go();
      wait_idle("zero table", 100);
      check("zero table pulses", pulse_cnt, p0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/timer_sequencer.md
TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: go  input  1  start sequence; sampled only in IDLE.
REQ-004 SHALL have port: abort  input  1  stop sequence; sampled in every non-IDLE state.
REQ-005 SHALL have port: loop  input  1  restart at entry 0 after last entry (see Configuration).
REQ-006 SHALL have port: seg_count  input  2  index of last table entry used (segments = seg_count+1).
REQ-007 SHALL have ports: cfg_we  input  1 / cfg_addr  input  2 / cfg_data  input  8  interval table write.
REQ-008 SHALL have ports: tmr_rst  output  1 / tmr_start  output  1 / tmr_mode  output  1 / tmr_set  output  8  drive the active-high-reset countdown timer.
REQ-009 SHALL have port: tmr_done  input  1  countdown-complete level from the timer.
REQ-010 SHALL have ports: busy  output  1 / seg_idx  output  2 / seg_pulse  output  1 / seq_done  output  1  status.

Function
REQ-011 SHALL hold a 4 x 8-bit interval table; cfg_we writes cfg_data to entry cfg_addr only while busy=0, and SHALL ignore writes while busy=1.
REQ-012 SHALL implement states IDLE, CLEAR, ARM, WAIT, NEXT, ABORT.
REQ-013 IDLE: go=1 and abort=0 -> CLEAR with seg_idx=0. go and abort both 1 -> remain IDLE.
REQ-014 CLEAR: tmr_rst=1 for exactly one cycle. Next state is ARM if table[seg_idx]!=0, else NEXT (zero entry skipped, no seg_pulse).
REQ-015 ARM: tmr_start=1, tmr_mode=1, tmr_set=table[seg_idx] for exactly one cycle, then WAIT.
REQ-016 tmr_set SHALL hold table[seg_idx] in ARM and WAIT. tmr_mode SHALL be 1 whenever busy=1.
REQ-017 WAIT: rising edge of tmr_done (registered previous value 0, current 1) -> NEXT with seg_pulse=1 for one cycle. A level already high on entry to WAIT SHALL NOT count.
REQ-018 NEXT: if seg_idx<seg_count -> seg_idx+1, CLEAR.
REQ-019 NEXT: if seg_idx==seg_count and loop active -> seg_idx=0, CLEAR.
REQ-020 NEXT: otherwise -> IDLE with seq_done=1 for one cycle.
REQ-021 abort=1 in CLEAR/ARM/WAIT/NEXT -> ABORT. ABORT holds tmr_rst=1 for one cycle, then goes to IDLE with no seq_done. Abort takes priority over a same-cycle tmr_done edge.
REQ-022 busy=1 in every state except IDLE. go while busy SHALL be ignored.
REQ-023 Latency: go sampled at edge N -> tmr_rst high during cycle N+1, tmr_start high during cycle N+2.
REQ-024 All-zero table -> visit CLEAR/NEXT per entry, then seq_done with no tmr_start ever asserted.
REQ-025 seg_count and loop are sampled live in NEXT, so changes mid-sequence take effect at the next NEXT.

Reset
REQ-026 reset low SHALL asynchronously force: state=IDLE, seg_idx=0, all table entries=0, tmr_rst=0, tmr_start=0, tmr_mode=0, tmr_set=0, busy=0, seg_pulse=0, seq_done=0, done-edge register=0.
REQ-027 Reset asserted mid-sequence SHALL abandon the sequence with no seq_done.

Configuration
REQ-028 Macro TIMER_SEQ_LOOP_EN defined: loop is honoured per REQ-019.
REQ-029 TIMER_SEQ_LOOP_EN undefined: loop port still exists but is ignored, and the sequence always ends per REQ-020.

Verification
REQ-030 Table {5,3,0,0}, seg_count=1, go pulse -> tmr_start twice with tmr_set 5 then 3; two seg_pulse; one seq_done; busy returns to 0.
REQ-031 Table {4,0,6,0}, seg_count=2 -> entry 1 skipped; exactly two tmr_start (4, 6); seq_idx visits 0,1,2; one seq_done.
REQ-032 abort asserted during WAIT of segment 0 -> one-cycle tmr_rst, IDLE next, no seg_pulse, no seq_done; a subsequent go restarts at seg_idx 0.
REQ-033 loop=1, seg_count=0, table {2,...}: with TIMER_SEQ_LOOP_EN -> repeated tmr_start with no seq_done until abort; without it -> one tmr_start, then seq_done.
REQ-034 cfg_we to entry 0 with 9 while busy -> table unchanged (next run still uses old value). go and abort high together in IDLE -> busy stays 0.
REQ-035 reset low during WAIT -> all outputs 0 immediately, before the next clk edge; table reads back as all zeros (all-zero run yields no tmr_start).
